// File: rtl/baudgen_pkg.sv
// Shared helpers for the baud tick generator: divisor, counter width and
// parameter legality, so every instance derives them the same way.
package baudgen_pkg;

    // Clocks per baud period (integer truncation). Zero when baud is zero.
    function automatic int unsigned baud_divisor(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return (baud == 0) ? 0 : clk_freq / baud;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Legal only if baud is nonzero and a period spans at least two clocks.
    function automatic bit baud_params_ok(input int unsigned clk_freq,
                                          input int unsigned baud);
        return (baud != 0) && (baud_divisor(clk_freq, baud) >= 2);
    endfunction

endpackage

// File: rtl/baud_counter.sv
// Modulo-N period counter.
//   clk, rst_n : clock, async active-low reset
//   en         : 1 = count, 0 = hold cleared
//   cnt        : current count 0..N-1
//   wrap       : combinational, high when enabled and cnt == N-1
module baud_counter
    import baudgen_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    output logic [cnt_width(N)-1:0]    cnt,
    output logic                       wrap
);

    localparam int unsigned CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    assign wrap = en && (cnt == LAST);

    // Disable clears rather than pauses, so a partial period is never resumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/baudgen.sv
// Baud tick generator: one-clock baud_tick every clk_freq/baud clocks while en.
//   clk, rst_n : clock, async active-low reset
//   en         : enable; deasserting clears the period
//   baud_tick  : registered one-clock pulse per baud period
//   half_tick  : (only with BAUDGEN_HALF_TICK_EN) registered pulse at the
//                period midpoint, for receiver mid-bit sampling
module baudgen
    import baudgen_pkg::*;
#(
    parameter int unsigned clk_freq = 12000000,
    parameter int unsigned baud     = 115200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
`ifdef BAUDGEN_HALF_TICK_EN
    output logic half_tick,
`endif
    output logic baud_tick
);

    localparam int unsigned N     = baud_divisor(clk_freq, baud);
    localparam int unsigned CNT_W = cnt_width(N);

    if (!baud_params_ok(clk_freq, baud)) begin : g_bad_params
        $error("baudgen: baud must be nonzero and clk_freq >= 2*baud");
    end

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    baud_counter #(
        .N (N)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    // wrap already carries en, so a disabled edge never produces a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_tick <= 1'b0;
        end else begin
            baud_tick <= wrap;
        end
    end

`ifdef BAUDGEN_HALF_TICK_EN
    localparam logic [CNT_W-1:0] HALF = CNT_W'(N / 2 - 1);

    // Midpoint pulse; HALF < N-1 for any legal N, so it never coincides with baud_tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_tick <= 1'b0;
        end else begin
            half_tick <= en && (cnt == HALF);
        end
    end
`endif

endmodule

// File: tb/tb_baudgen.sv
// Scoreboard bench for baudgen: stimulus pushes expected tick edge numbers,
// monitors pop and compare whenever a tick appears.
module tb_baudgen;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic en4;
    logic baud_tick;
    logic baud_tick4;
`ifdef BAUDGEN_HALF_TICK_EN
    logic half_tick;
    logic half_tick4;
`endif

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int q[$];
    int q4[$];
`ifdef BAUDGEN_HALF_TICK_EN
    int qh[$];
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    baudgen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
`ifdef BAUDGEN_HALF_TICK_EN
        .half_tick (half_tick),
`endif
        .baud_tick (baud_tick)
    );

    baudgen #(.clk_freq(4), .baud(1)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en4),
`ifdef BAUDGEN_HALF_TICK_EN
        .half_tick (half_tick4),
`endif
        .baud_tick (baud_tick4)
    );

    // Monitor: default instance.
    int exp_m;
    always @(negedge clk) begin
        if (baud_tick) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL tick_unexpected: baud_tick high after edge %0d, required low", cyc);
            end else begin
                exp_m = q.pop_front();
                if (exp_m != cyc) begin
                    errors++;
                    $display("FAIL tick_edge: baud_tick after edge %0d, required after edge %0d", cyc, exp_m);
                end
            end
        end
    end

    // Monitor: N=4 instance.
    int exp_m4;
    always @(negedge clk) begin
        if (baud_tick4) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL tick4_unexpected: baud_tick high after edge %0d, required low", cyc);
            end else begin
                exp_m4 = q4.pop_front();
                if (exp_m4 != cyc) begin
                    errors++;
                    $display("FAIL tick4_edge: baud_tick after edge %0d, required after edge %0d", cyc, exp_m4);
                end
            end
        end
    end

`ifdef BAUDGEN_HALF_TICK_EN
    // Monitor: half tick, plus exclusivity with baud_tick.
    int exp_h;
    always @(negedge clk) begin
        if (half_tick) begin
            checks++;
            if (q_h_empty()) begin
                errors++;
                $display("FAIL half_unexpected: half_tick high after edge %0d, required low", cyc);
            end else begin
                exp_h = qh.pop_front();
                if (exp_h != cyc) begin
                    errors++;
                    $display("FAIL half_edge: half_tick after edge %0d, required after edge %0d", cyc, exp_h);
                end
            end
            checks++;
            if (baud_tick) begin
                errors++;
                $display("FAIL half_and_baud: both high after edge %0d, required exclusive", cyc);
            end
        end
    end

    function automatic bit q_h_empty();
        return qh.size() == 0;
    endfunction
`endif

    task automatic wait_negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Check away from the negedge monitors.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    int e;

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        en4   = 1'b0;

        // Reset state: en held high must not count while in reset.
        repeat (4) @(posedge clk);
        #1;
        check_val("reset_tick", int'(baud_tick), 0);
        check_val("reset_cnt", int'(dut.u_counter.cnt), 0);
        check_val("reset_tick4", int'(baud_tick4), 0);

        // Release with en high: first tick 104 edges later.
        @(negedge clk);
        rst_n = 1'b1;
        e = cyc;
        q.push_back(e + 104);
        wait_negs(104);
        en = 1'b0;
        settle();
        check_val("release_drain", q.size(), 0);

        // Continuous run: ten ticks at 104, 208, ... 1040.
        @(negedge clk);
        en = 1'b1;
        e = cyc;
        for (int i = 1; i <= 10; i++) q.push_back(e + 104 * i);
        wait_negs(1040);
        en = 1'b0;
        wait_negs(2);
        settle();
        check_val("run10_drain", q.size(), 0);

        // Enable drop after 60 edges for 5 edges: full period restarts.
        @(negedge clk);
        en = 1'b1;
        wait_negs(60);
        en = 1'b0;
        wait_negs(5);
        en = 1'b1;
        e = cyc;
        q.push_back(e + 104);
        q.push_back(e + 208);
        wait_negs(208);
        en = 1'b0;
        wait_negs(2);
        settle();
        check_val("endrop_drain", q.size(), 0);

        // Reset mid-period at edge 80 for 3 clocks: no tick, full restart.
        @(negedge clk);
        en = 1'b1;
        wait_negs(79);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midreset_cnt", int'(dut.u_counter.cnt), 0);
        repeat (3) @(posedge clk);
        #1;
        check_val("midreset_tick", int'(baud_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        e = cyc;
        q.push_back(e + 104);
        wait_negs(104);
        en = 1'b0;
        wait_negs(2);
        settle();
        check_val("midreset_drain", q.size(), 0);

        // en falls exactly when cnt == 103: no tick, counter cleared.
        @(negedge clk);
        en = 1'b1;
        wait_negs(103);
        check_val("collide_cnt_before", int'(dut.u_counter.cnt), 103);
        en = 1'b0;
        settle();
        check_val("collide_tick", int'(baud_tick), 0);
        check_val("collide_cnt_after", int'(dut.u_counter.cnt), 0);
        wait_negs(3);
        settle();
        check_val("collide_drain", q.size(), 0);

        // Small divisor N=4: ticks at 4, 8, 12.
        @(negedge clk);
        en4 = 1'b1;
        e = cyc;
        for (int i = 1; i <= 3; i++) q4.push_back(e + 4 * i);
        wait_negs(12);
        en4 = 1'b0;
        wait_negs(2);
        settle();
        check_val("n4_drain", q4.size(), 0);

`ifdef BAUDGEN_HALF_TICK_EN
        // Half tick at 52, 156, 260; baud tick at 104, 208, 312.
        @(negedge clk);
        en = 1'b1;
        e = cyc;
        for (int i = 0; i < 3; i++) begin
            qh.push_back(e + 52 + 104 * i);
            q.push_back(e + 104 * (i + 1));
        end
        wait_negs(312);
        en = 1'b0;
        wait_negs(2);
        settle();
        check_val("half_drain", qh.size(), 0);
        check_val("half_baud_drain", q.size(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/baudgen.md
BAUDGEN -- requirements
Module: baudgen

Interface
REQ-001 SHALL have parameter clk_freq, default 12000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter baud, default 115200, meaning target tick rate in Hz.
REQ-003 SHALL have port clk  input  1  rising-edge clock (one clock; all logic in this domain).
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  enable; 1 = count, 0 = hold counter cleared.
REQ-006 SHALL have port baud_tick  output  1  one-clock pulse per baud period.

Function
REQ-007 SHALL compute divisor N = clk_freq / baud (integer truncation); for the defaults N = 104.
REQ-008 SHALL size the counter CNT_W = $clog2(N) bits, minimum 1; no wider arithmetic is stored.
REQ-009 SHALL, on each rising edge with en=1: if cnt == N-1 then cnt <= 0, else cnt <= cnt+1.
REQ-010 SHALL, on each rising edge with en=0, force cnt <= 0 and baud_tick <= 0.
REQ-011 SHALL register baud_tick <= 1 on the edge where en=1 and cnt == N-1, else 0; the pulse lasts exactly one clock.
REQ-012 SHALL produce the first tick after the N-th consecutive rising edge sampled with en=1, then one every N edges (period exactly N clocks, no drift).
REQ-013 SHALL restart a full N-cycle period when en is deasserted for at least one edge and then reasserted; a partial count is never resumed.
REQ-014 SHALL, when en falls on the same edge where cnt == N-1, emit no tick (en=0 has priority).
REQ-015 SHALL have no combinational path from en to baud_tick.

Reset
REQ-016 SHALL, while rst_n=0, asynchronously clear cnt to 0, baud_tick to 0 and half_tick (if present) to 0.
REQ-017 SHALL, after rst_n rises, behave as if en had just risen: first tick after N enabled edges.
REQ-018 SHALL abort any count in progress when reset is asserted mid-period; no pending tick survives reset.

Configuration
REQ-019 SHALL, when macro BAUDGEN_HALF_TICK_EN is defined, add output half_tick (1 bit), registered high for one clock on the edge where en=1 and cnt == N/2 - 1 (floor), i.e. 52 edges into each 104-edge period, for UART receive mid-bit sampling.
REQ-020 SHALL, without BAUDGEN_HALF_TICK_EN, omit the half_tick port and its logic entirely; baud_tick behaviour is identical in both builds.

Structure
REQ-021 SHALL place a constant function for N and the CNT_W width computation in shared package baudgen_pkg.
REQ-022 SHALL raise an elaboration error if baud == 0 or N < 2 (clk_freq < 2*baud); the same check SHALL live in baudgen_pkg.
REQ-023 SHALL implement the counter as one sub-module baud_counter (parameter N; ports clk, rst_n, en, cnt, wrap); baudgen adds the output registers.

Verification
REQ-024 SHALL check defaults: rst_n released, en=1 held -> baud_tick pulses one clock wide after enabled edges 104, 208, ..., 1040 (10 ticks), low at all other edges.
REQ-025 SHALL check enable drop: en=1 for 60 edges, en=0 for 5, en=1 -> no tick at edge 104; next tick 104 edges after re-enable.
REQ-026 SHALL check reset mid-period: en=1, assert rst_n=0 asynchronously at edge 80 for 3 clocks -> baud_tick stays 0; first tick 104 enabled edges after release.
REQ-027 SHALL check small divisor: clk_freq=4, baud=1 (N=4) -> ticks after enabled edges 4, 8, 12; clk_freq=3, baud=2 -> elaboration error.
REQ-028 SHALL check BAUDGEN_HALF_TICK_EN build: defaults, en=1 -> half_tick after enabled edges 52, 156, 260; baud_tick at 104, 208, 312; never both high on the same clock.
REQ-029 SHALL check en-fall collision: en deasserted exactly at the edge where cnt == 103 -> no tick that cycle, cnt reads 0 afterwards.
